// File: rtl/axi_sram_if.sv
// axi_sram_if: single-beat AXI4 link between a master (fetch/LSU/arbiter)
// and the axi_sram_resp memory model.
//   AR: araddr, arid, arlen, arsize, arvalid -> ; <- arready
//   R : <- rdata, rresp, rid, rlast, rvalid ; rready ->
//   AW: awaddr, awid, awvalid -> ; <- awready
//   W : wdata, wstrb, wlast, wvalid -> ; <- wready
//   B : <- bresp, bid, bvalid ; bready ->
// Modports: master (drives requests / ready for responses), slave (memory).
interface axi_sram_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arvalid, input arready,
        input  rdata, rresp, rid, rlast, rvalid, output rready,
        output awaddr, awid, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bid, bvalid, output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arvalid, output arready,
        output rdata, rresp, rid, rlast, rvalid, input rready,
        input  awaddr, awid, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bid, bvalid, input bready
    );
endinterface

// File: rtl/axi_sram_resp.sv
// axi_sram_resp: AXI4 slave memory model, single-beat reads and writes,
// word-addressed SRAM with byte strobes and a programmable response delay.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (array contents are retained)
//   bus   - axi_sram_if.slave (AR/R/AW/W/B channels)
// Parameters: ADDR_BASE (byte address of word 0), DEPTH_WORDS (power of 2),
//   LAT (fixed delay 0..15).
// Build option: SRAM_RAND_DELAY_EN - when defined, each transaction's delay
//   is taken from an 8-bit LFSR (0..7 cycles) instead of LAT.
// Latency: handshake in cycle T -> rvalid/bvalid in cycle T+1+D.
module axi_sram_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_sram_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  dly;
    logic        awGot, wGot;
    logic [31:0] arAddrQ, awAddrQ, wDataQ;
    logic [3:0]  wStrbQ;
    logic [31:0] rdataQ;
    logic [1:0]  rrespQ, brespQ;
    logic [3:0]  ridQ, bidQ;
    logic        rvalidQ, rlastQ, bvalidQ;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic inRange(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ((off >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] toIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IDX_W+1:2];
    endfunction

`ifdef SRAM_RAND_DELAY_EN
    // x^8+x^6+x^5+x^4+1, free-running; delay sampled at the accepting handshake.
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign dly = {1'b0, lfsr[2:0]};
`else
    assign dly = 4'(LAT);
`endif

    // Readies are decoded, not registered; reads have priority over writes.
    assign bus.arready = rst_n && (state == IDLE);
    assign bus.awready = rst_n && (state == IDLE) && !awGot && !bus.arvalid;
    assign bus.wready  = rst_n && (state == IDLE) && !wGot  && !bus.arvalid;

    logic arHs, awHs, wHs, wrGo;
    assign arHs = bus.arvalid && bus.arready;
    assign awHs = bus.awvalid && bus.awready;
    assign wHs  = bus.wvalid  && bus.wready;

    // Read source: live address at AR handshake, latched address afterwards.
    logic [31:0] rdAddr, rdWord;
    logic        rdOk;
    assign rdAddr = (state == IDLE) ? bus.araddr : arAddrQ;
    assign rdOk   = inRange(rdAddr);
    assign rdWord = mem[toIdx(rdAddr)];

    // Write fields come from the latch once a channel has been taken, so the
    // same path serves the immediate (D=0) and delayed cases.
    logic [31:0] wrAddr, wrData;
    logic [3:0]  wrStrb;
    logic        wrOk, memWe;
    assign wrAddr = awGot ? awAddrQ : bus.awaddr;
    assign wrData = wGot  ? wDataQ  : bus.wdata;
    assign wrStrb = wGot  ? wStrbQ  : bus.wstrb;
    assign wrOk   = inRange(wrAddr);
    assign wrGo   = (state == IDLE) && !arHs && (awGot || awHs) && (wGot || wHs);
    assign memWe  = wrOk && ((wrGo && dly == 4'd0) || (state == WR_WAIT && cnt == 4'd0));

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++)
                if (wrStrb[b]) mem[toIdx(wrAddr)][8*b +: 8] <= wrData[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            awGot   <= 1'b0;
            wGot    <= 1'b0;
            arAddrQ <= '0;
            awAddrQ <= '0;
            wDataQ  <= '0;
            wStrbQ  <= '0;
            rdataQ  <= '0;
            rrespQ  <= OKAY;
            ridQ    <= '0;
            rvalidQ <= 1'b0;
            rlastQ  <= 1'b0;
            brespQ  <= OKAY;
            bidQ    <= '0;
            bvalidQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arHs) begin
                        arAddrQ <= bus.araddr;
                        ridQ    <= bus.arid;
                        if (dly == 4'd0) begin
                            rdataQ  <= rdOk ? rdWord : 32'h0;
                            rrespQ  <= rdOk ? OKAY : SLVERR;
                            rvalidQ <= 1'b1;
                            rlastQ  <= 1'b1;
                            state   <= RD_RESP;
                        end else begin
                            cnt   <= dly - 4'd1;
                            state <= RD_WAIT;
                        end
                    end else begin
                        if (awHs) begin
                            awGot   <= 1'b1;
                            awAddrQ <= bus.awaddr;
                            bidQ    <= bus.awid;
                        end
                        if (wHs) begin
                            wGot   <= 1'b1;
                            wDataQ <= bus.wdata;
                            wStrbQ <= bus.wstrb;
                        end
                        if (wrGo) begin
                            if (dly == 4'd0) begin
                                awGot   <= 1'b0;
                                wGot    <= 1'b0;
                                brespQ  <= wrOk ? OKAY : SLVERR;
                                bvalidQ <= 1'b1;
                                state   <= WR_RESP;
                            end else begin
                                cnt   <= dly - 4'd1;
                                state <= WR_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        rdataQ  <= rdOk ? rdWord : 32'h0;
                        rrespQ  <= rdOk ? OKAY : SLVERR;
                        rvalidQ <= 1'b1;
                        rlastQ  <= 1'b1;
                        state   <= RD_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (bus.rready) begin
                        rvalidQ <= 1'b0;
                        rlastQ  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd0) begin
                        awGot   <= 1'b0;
                        wGot    <= 1'b0;
                        brespQ  <= wrOk ? OKAY : SLVERR;
                        bvalidQ <= 1'b1;
                        state   <= WR_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        bvalidQ <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata  = rdataQ;
    assign bus.rresp  = rrespQ;
    assign bus.rid    = ridQ;
    assign bus.rlast  = rlastQ;
    assign bus.rvalid = rvalidQ;
    assign bus.bresp  = brespQ;
    assign bus.bid    = bidQ;
    assign bus.bvalid = bvalidQ;

    // Burst length/size and wlast are ignored: only single beats exist.
    logic unusedBits;
    assign unusedBits = ^{bus.arlen, bus.arsize, bus.wlast};
endmodule

// File: tb/tb_axi_sram_resp.sv
module tb_axi_sram_resp;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi_sram_if bus();

    axi_sram_resp dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkLat(input string name, input int lat);
        nChecks++;
`ifdef SRAM_RAND_DELAY_EN
        if (lat < 1 || lat > 8) begin
            nFail++;
            $display("FAIL %s: latency %0d expected 1..8", name, lat);
        end
`else
        if (lat != 2) begin
            nFail++;
            $display("FAIL %s: latency %0d expected 2", name, lat);
        end
`endif
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic doRead(input logic [31:0] addr, input logic [3:0] id,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] rid, output int lat);
        int guard;
        bit ok;
        bus.araddr = addr; bus.arid = id; bus.arvalid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk); guard++; ok = bus.arready;
            @(posedge clk); #1;
        end while (!ok && guard < 40);
        bus.arvalid = 1'b0;
        chk("ar_accept", 32'(ok), 32'd1);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rvalid && lat < 40);
        chk("rvalid_seen", 32'(bus.rvalid), 32'd1);
        data = bus.rdata; resp = bus.rresp; rid = bus.rid;
        bus.rready = 1'b1;
        @(posedge clk); #1 bus.rready = 1'b0;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [3:0] id,
                           output logic [1:0] resp, output logic [3:0] bid, output int lat);
        int guard;
        bit aHs, wHs, aDone, wDone;
        bus.awaddr = addr; bus.awid = id; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        aDone = 0; wDone = 0; guard = 0;
        do begin
            @(negedge clk); guard++;
            aHs = bus.awvalid && bus.awready;
            wHs = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aHs) begin bus.awvalid = 1'b0; aDone = 1; end
            if (wHs) begin bus.wvalid = 1'b0; wDone = 1; end
        end while (!(aDone && wDone) && guard < 40);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("aw_w_accept", 32'(aDone && wDone), 32'd1);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.bvalid && lat < 40);
        chk("bvalid_seen", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp; bid = bus.bid;
        bus.bready = 1'b1;
        @(posedge clk); #1 bus.bready = 1'b0;
    endtask

    typedef struct {
        bit          isWr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d0;
        logic [1:0]  r;
        logic [3:0]  id;
        int          lat, guard;

        bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awaddr = '0; bus.awid = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 2'b00};
        vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00};
        vecs[4]  = '{1'b0, 32'h8000_0020, 32'h11BB_33DD, 4'h0, 2'b00};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00};
        vecs[6]  = '{1'b1, 32'h8000_3FFC, 32'h1234_5678, 4'hF, 2'b00};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 2'b10};
        vecs[8]  = '{1'b0, 32'h8000_4000, 32'h0000_0000, 4'h0, 2'b10};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b10};
        vecs[10] = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'hCAFE_F00D, 4'h0, 2'b00};
        vecs[12] = '{1'b0, 32'h8000_3FFC, 32'h1234_5678, 4'h0, 2'b00};
        vecs[13] = '{1'b0, 32'h8000_0013, 32'hDEAD_BEEF, 4'h0, 2'b00};
        vecs[14] = '{1'b1, 32'h8000_0020, 32'h0000_0000, 4'h0, 2'b00};
        vecs[15] = '{1'b0, 32'h8000_0020, 32'h11BB_33DD, 4'h0, 2'b00};

        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rlast",   32'(bus.rlast),   32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        chk("rst_rresp",   32'(bus.rresp),   32'd0);
        chk("rst_rid",     32'(bus.rid),     32'd0);
        chk("rst_bresp",   32'(bus.bresp),   32'd0);
        chk("rst_bid",     32'(bus.bid),     32'd0);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready",  32'(bus.wready),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].isWr) begin
                doWrite(vecs[i].addr, vecs[i].data, vecs[i].strb, 4'(i), r, id, lat);
                chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
                chk($sformatf("v%0d_bid", i), 32'(id), 32'(i));
                chkLat($sformatf("v%0d_blat", i), lat);
            end else begin
                doRead(vecs[i].addr, 4'(i), d, r, id, lat);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].data);
                chk($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
                chk($sformatf("v%0d_rid", i), 32'(id), 32'(i));
                chkLat($sformatf("v%0d_rlat", i), lat);
            end
        end

        // W three cycles ahead of AW; second W must be held off
        bus.wdata = 32'h5566_7788; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk); chk("wfirst_wready", 32'(bus.wready), 32'd1);
        @(posedge clk); #1 bus.wdata = 32'h9999_9999;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("wsecond_wready", 32'(bus.wready), 32'd0);
            chk("wonly_bvalid", 32'(bus.bvalid), 32'd0);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        bus.awaddr = 32'h8000_0030; bus.awid = 4'd7; bus.awvalid = 1'b1;
        @(negedge clk); chk("wfirst_awready", 32'(bus.awready), 32'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.bvalid && lat < 40);
        chk("wfirst_bvalid", 32'(bus.bvalid), 32'd1);
        chk("wfirst_bid", 32'(bus.bid), 32'd7);
        chkLat("wfirst_blat", lat);
        bus.bready = 1'b1;
        @(posedge clk); #1 bus.bready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("wfirst_single_b", 32'(bus.bvalid), 32'd0);
            @(posedge clk); #1;
        end
        doRead(32'h8000_0030, 4'd3, d, r, id, lat);
        chk("wfirst_rdata", d, 32'h5566_7788);

        // Back-pressure on R, with the next AR already waiting
        bus.araddr = 32'h8000_0010; bus.arid = 4'd9; bus.arvalid = 1'b1;
        @(negedge clk); chk("bp_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1 bus.araddr = 32'h8000_0020; bus.arid = 4'd10;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.rvalid && guard < 40);
        chk("bp_rvalid", 32'(bus.rvalid), 32'd1);
        d0 = bus.rdata;
        chk("bp_rdata", d0, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_rvalid", 32'(bus.rvalid), 32'd1);
            chk("bp_hold_rdata", bus.rdata, 32'hDEAD_BEEF);
            chk("bp_hold_rid", 32'(bus.rid), 32'd9);
            chk("bp_hold_arready", 32'(bus.arready), 32'd0);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1 bus.rready = 1'b0;
        @(negedge clk); chk("bp_next_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1 bus.arvalid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.rvalid && guard < 40);
        chk("bp_next_rdata", bus.rdata, 32'h11BB_33DD);
        chk("bp_next_rid", 32'(bus.rid), 32'd10);
        bus.rready = 1'b1;
        @(posedge clk); #1 bus.rready = 1'b0;

        // Simultaneous AR and AW/W: read wins and sees old data
        doWrite(32'h8000_0040, 32'h0101_0101, 4'hF, 4'd1, r, id, lat);
        bus.araddr = 32'h8000_0040; bus.arid = 4'd2; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0040; bus.awid = 4'd4; bus.awvalid = 1'b1;
        bus.wdata = 32'h0BAD_CAFE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("sim_arready", 32'(bus.arready), 32'd1);
        chk("sim_awready", 32'(bus.awready), 32'd0);
        chk("sim_wready",  32'(bus.wready),  32'd0);
        @(posedge clk); #1 bus.arvalid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.rvalid && guard < 40);
        chk("sim_rdata", bus.rdata, 32'h0101_0101);
        bus.rready = 1'b1;
        @(posedge clk); #1 bus.rready = 1'b0;
        @(negedge clk);
        chk("sim_aw_after", 32'(bus.awready && bus.wready), 32'd1);
        @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!bus.bvalid && guard < 40);
        chk("sim_bid", 32'(bus.bid), 32'd4);
        bus.bready = 1'b1;
        @(posedge clk); #1 bus.bready = 1'b0;
        doRead(32'h8000_0040, 4'd5, d, r, id, lat);
        chk("sim_after_write", d, 32'h0BAD_CAFE);

        // Reset pulse while a read is waiting
        bus.araddr = 32'h8000_0010; bus.arid = 4'd6; bus.arvalid = 1'b1;
        @(negedge clk); chk("rstmid_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1 bus.arvalid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rstmid_arready_low", 32'(bus.arready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("rstmid_rvalid2", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_idle_arready", 32'(bus.arready), 32'd1);
        chk("rstmid_rvalid3", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1;
        doRead(32'h8000_0010, 4'd8, d, r, id, lat);
        chk("rstmid_retained", d, 32'hDEAD_BEEF);
        chk("rstmid_rid", 32'(id), 32'd8);

`ifdef SRAM_RAND_DELAY_EN
        for (int k = 0; k < 1000; k++) begin
            doRead(32'h8000_0020, 4'(k), d, r, id, lat);
            chkLat("rand_lat", lat);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
